// File: rtl/lsu_pkg.sv
// Shared types and constants for the TRV-32I load/store unit.
package lsu_pkg;

    localparam int unsigned LSU_XLEN  = 32;
    localparam int unsigned LSU_LANES = LSU_XLEN / 8;

    // RV32I load/store funct3 encodings (stores use B/H/W only)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_t;

    // Request captured from the execute stage on handshake
    typedef struct packed {
        logic                store;
        logic [2:0]          funct3;
        logic [LSU_XLEN-1:0] addr;
        logic [LSU_XLEN-1:0] wdata;
    } lsu_req_t;

    // Misaligned access or funct3 not legal for the access direction
    function automatic logic lsu_access_err(input logic       store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] off);
        logic err;
        err = 1'b0;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = |off;
            F3_BU:   err = store;
            F3_HU:   err = store | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Sub-word alignment: byte enables, store lane replication, load lane select/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic                 store_i,
    input  logic [2:0]           funct3_i,
    input  logic [1:0]           off_i,
    input  logic [LSU_XLEN-1:0]  wdata_i,
    input  logic [LSU_XLEN-1:0]  bus_rdata_i,
    output logic [LSU_LANES-1:0] byte_en_o,
    output logic [LSU_XLEN-1:0]  wdata_rep_o,
    output logic [LSU_XLEN-1:0]  rdata_ext_o,
    output logic                 err_o
);

    localparam int unsigned BYTE_PAD = LSU_XLEN - 8;
    localparam int unsigned HALF_PAD = LSU_XLEN - 16;

    logic [LSU_LANES-1:0] base_en;
    logic [LSU_XLEN-1:0]  shifted;
    logic                 sign_ext;

    // Write-side: lane enables shifted to the byte offset, data replicated across lanes
    always_comb begin
        base_en     = LSU_LANES'(4'b1111);
        wdata_rep_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                base_en     = LSU_LANES'(4'b0001);
                wdata_rep_o = {LSU_LANES{wdata_i[7:0]}};
            end
            2'b01: begin
                base_en     = LSU_LANES'(4'b0011);
                wdata_rep_o = {(LSU_LANES/2){wdata_i[15:0]}};
            end
            default: begin
                base_en     = LSU_LANES'(4'b1111);
                wdata_rep_o = wdata_i;
            end
        endcase
        byte_en_o = LSU_LANES'(base_en << off_i);
    end

    // Read-side: bring the addressed lane down to bit 0, then sign or zero extend
    always_comb begin
        shifted     = bus_rdata_i >> {off_i, 3'b000};
        sign_ext    = ~funct3_i[2];
        rdata_ext_o = shifted;
        case (funct3_i[1:0])
            2'b00:   rdata_ext_o = {{BYTE_PAD{sign_ext & shifted[7]}}, shifted[7:0]};
            2'b01:   rdata_ext_o = {{HALF_PAD{sign_ext & shifted[15]}}, shifted[15:0]};
            default: rdata_ext_o = shifted;
        endcase
    end

    assign err_o = lsu_access_err(store_i, funct3_i, off_i);

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: sequences one load or store at a time onto the data-memory port.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned B_WIDTH  = 32,
    parameter int unsigned MEM_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [2:0]           req_funct3,
    input  logic [B_WIDTH-1:0]   req_addr,
    input  logic [B_WIDTH-1:0]   req_wdata,
    output logic                 resp_valid,
    output logic [B_WIDTH-1:0]   resp_rdata,
    output logic                 resp_err,
    output logic [B_WIDTH-1:0]   mem_addr,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [B_WIDTH/8-1:0] write_byte_en,
    inout  wire  [B_WIDTH-1:0]   mem_data
);

    localparam logic [B_WIDTH-1:0] WADDR_MASK = (MEM_SIZE >= B_WIDTH) ?
        {B_WIDTH{1'b1}} : B_WIDTH'((64'd1 << MEM_SIZE) - 64'd1);

    lsu_state_t           state_q, state_d;
    lsu_req_t             req_q;
    logic [B_WIDTH-1:0]   resp_rdata_q;
    logic                 handshake;
    logic                 bus_drive;
    logic [B_WIDTH-1:0]   word_addr;

    logic [LSU_LANES-1:0] align_be;
    logic [LSU_XLEN-1:0]  align_wdata;
    logic [LSU_XLEN-1:0]  align_rdata;
    logic                 align_err;

    assign handshake = req_valid & req_ready;
    assign word_addr = B_WIDTH'(req_q.addr >> 2) & WADDR_MASK;

    lsu_align u_align (
        .store_i     (req_q.store),
        .funct3_i    (req_q.funct3),
        .off_i       (req_q.addr[1:0]),
        .wdata_i     (req_q.wdata),
        .bus_rdata_i (LSU_XLEN'(mem_data)),
        .byte_en_o   (align_be),
        .wdata_rep_o (align_wdata),
        .rdata_ext_o (align_rdata),
        .err_o       (align_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: errors skip straight to the response cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    if (lsu_access_err(req_store, req_funct3, req_addr[1:0])) begin
                        state_d = ST_RESP;
                    end else if (req_store) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: state_d = ST_RD_DATA;
            ST_RD_DATA: state_d = ST_RESP;
            ST_WR:      state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register and the captured request
    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        write_byte_en = '0;
        mem_addr      = '0;
        bus_drive     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_RD_ADDR, ST_RD_DATA: begin
                mem_read_en = 1'b1;
                mem_addr    = word_addr;
            end
            ST_WR: begin
                mem_write_en  = 1'b1;
                write_byte_en = (B_WIDTH/8)'(align_be);
                bus_drive     = 1'b1;
                mem_addr      = word_addr;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = align_err;
                mem_addr   = word_addr;
            end
            default: ;
        endcase
    end

    // Request capture on handshake; load result captured while the bus holds the word
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q        <= '0;
            resp_rdata_q <= '0;
        end else if (handshake) begin
            req_q.store  <= req_store;
            req_q.funct3 <= req_funct3;
            req_q.addr   <= LSU_XLEN'(req_addr);
            req_q.wdata  <= LSU_XLEN'(req_wdata);
            resp_rdata_q <= '0;
        end else if (state_q == ST_RD_DATA) begin
            resp_rdata_q <= B_WIDTH'(align_rdata);
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign mem_data   = bus_drive ? B_WIDTH'(align_wdata) : {B_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: vector table, response scoreboard, reset and busy corner cases.
module tb_mem_lsu;

    localparam logic [31:0] PULL = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [3:0]  write_byte_en;
    wire  [31:0] mem_data;

    always #5 clk = ~clk;

    mem_lsu #(.B_WIDTH(32), .MEM_SIZE(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_store     (req_store),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_addr      (mem_addr),
        .mem_read_en   (mem_read_en),
        .mem_write_en  (mem_write_en),
        .write_byte_en (write_byte_en),
        .mem_data      (mem_data)
    );

    // Data memory model: one-cycle read latency, byte-lane writes, bus keeper when idle
    logic [31:0] mem [64];
    logic [31:0] mem_rdq;
    logic        mem_drive_q;
    logic        pull_en;

    assign pull_en  = !mem_drive_q && !mem_write_en;
    assign mem_data = mem_drive_q ? mem_rdq : 32'bz;
    assign mem_data = pull_en ? PULL : 32'bz;

    always @(posedge clk) begin
        if (rst) mem_drive_q <= 1'b0;
        else     mem_drive_q <= mem_read_en;
        if (mem_read_en) mem_rdq <= mem[mem_addr[5:0]];
        if (mem_write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (write_byte_en[i]) mem[mem_addr[5:0]][8*i +: 8] <= mem_data[8*i +: 8];
            end
        end
    end

    // Check bookkeeping
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Scoreboard of expected responses
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    // Vector table
    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_bus;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input logic er,
                                input logic [3:0] be, input logic [31:0] bus);
        vec_t v;
        v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_rdata = rd; v.exp_err = er; v.exp_be = be; v.exp_bus = bus;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        int   exp_lat;
        exp_t e;
        @(negedge clk);
        chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_store  = v.store;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr >> 2);
        if (v.exp_err) begin
            chk($sformatf("v%0d_err_strobes", idx), {30'd0, mem_read_en, mem_write_en}, 32'd0);
        end else if (v.store) begin
            chk($sformatf("v%0d_wr_strobes", idx), {30'd0, mem_read_en, mem_write_en}, 32'd1);
            chk($sformatf("v%0d_byte_en", idx), 32'(write_byte_en), 32'(v.exp_be));
            chk($sformatf("v%0d_bus", idx), mem_data, v.exp_bus);
        end else begin
            chk($sformatf("v%0d_rd_strobes", idx), {30'd0, mem_read_en, mem_write_en}, 32'd2);
            chk($sformatf("v%0d_rd_be", idx), 32'(write_byte_en), 32'd0);
        end
        exp_lat = v.exp_err ? 1 : (v.store ? 2 : 3);
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Loads/stores build on one another: memory contents are tracked by hand
        vecs.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 4'hF, 32'hDEADBEEF));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h10, 32'h11223344, 32'h0,        0, 4'hF, 32'h11223344));
        vecs.push_back(mk(1, 3'b000, 32'h13, 32'h000000A5, 32'h0,        0, 4'h8, 32'hA5A5A5A5));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0,        32'hA5223344, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFA5, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'h13, 32'h0,        32'h000000A5, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h11, 32'h0,        32'h00000033, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h10, 32'h0,        32'h00003344, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h20, 32'h0,        32'h0,        0, 4'hF, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h22, 32'h12348001, 32'h0,        0, 4'hC, 32'h80018001));
        vecs.push_back(mk(0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h22, 32'h0,        32'h00008001, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0,        32'h80010000, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, 3'b000, 32'h21, 32'hFFFFFF7F, 32'h0,        0, 4'h2, 32'h7F7F7F7F));
        vecs.push_back(mk(0, 3'b000, 32'h21, 32'h0,        32'h0000007F, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h20, 32'h0,        32'h00007F00, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h06, 32'h0,        32'h0,        1, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h03, 32'h0,        32'h0,        1, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h00, 32'h0,        32'h0,        1, 4'h0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h12, 32'hCAFEF00D, 32'h0,        1, 4'h0, 32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h10, 32'hCAFEF00D, 32'h0,        1, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b110, 32'h10, 32'h0,        32'h0,        1, 4'h0, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h11, 32'hCAFEF00D, 32'h0,        1, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0,        32'hA5223344, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h12, 32'h0,        32'h00000022, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h12, 32'h0,        32'hFFFFA522, 0, 4'h0, 32'h0));

        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;

        // Reset state with the bus held by the keeper
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        chk("rst_strobes", {30'd0, mem_read_en, mem_write_en}, 32'd0);
        chk("rst_byte_en", 32'(write_byte_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_bus", mem_data, PULL);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Request held while busy must be ignored (store would clobber word 4)
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        sb.push_back('{rdata: 32'hA5223344, err: 1'b0});
        @(posedge clk);
        @(negedge clk);
        req_store = 1'b1; req_wdata = 32'h0BADF00D;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("busy_ready_c%0d", c), 32'(req_ready), 32'd0);
            if (c == 3) req_valid = 1'b0;
            else @(negedge clk);
        end
        run_vec(mk(0, 3'b010, 32'h10, 32'h0, 32'hA5223344, 0, 4'h0, 32'h0), 100);

        // Reset during RD_DATA drops the load
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rd_rst_pre_read_en", 32'(mem_read_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rd_rst_strobes", {30'd0, mem_read_en, mem_write_en}, 32'd0);
        chk("rd_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rd_rst_ready", 32'(req_ready), 32'd1);
        chk("rd_rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during WR releases the bus and drops the response
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h24; req_wdata = 32'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("wr_rst_pre_bus", mem_data, 32'h55AA55AA);
        rst = 1'b1;
        @(negedge clk);
        chk("wr_rst_strobes", {30'd0, mem_read_en, mem_write_en}, 32'd0);
        chk("wr_rst_byte_en", 32'(write_byte_en), 32'd0);
        chk("wr_rst_bus", mem_data, PULL);
        chk("wr_rst_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_bus", mem_data, PULL);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for TRV-32I: the initiator side of the data-memory port. Accepts one load or store at a time from the execute stage and sequences the memory's word-addressed, one-cycle-read-latency, shared tristate data bus. Handles RV32I sub-word accesses: byte enables, store-lane replication, load sign/zero extension and misalignment detection. Sits between the EX/MEM pipeline register and the data memory.

## Interface
- `B_WIDTH`, 32, data and address width; must be 32 for RV32I semantics.
- `MEM_SIZE`, 32, word-address bits used by the data memory; upper `mem_addr` bits above `MEM_SIZE` driven 0.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU idle and accepting; handshake on `req_valid & req_ready`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- `req_addr`  in  B_WIDTH  byte address.
- `req_wdata`  in  B_WIDTH  store data, right-aligned.
- `resp_valid`  out  1  one-cycle pulse, completion of accepted request.
- `resp_rdata`  out  B_WIDTH  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access or illegal funct3; valid with `resp_valid`.
- `mem_addr`  out  B_WIDTH  word address = `req_addr >> 2`.
- `mem_read_en`  out  1  memory read strobe.
- `mem_write_en`  out  1  memory write strobe.
- `write_byte_en`  out  B_WIDTH/8  per-byte write lane enables.
- `mem_data`  inout  B_WIDTH  shared data bus; LSU drives only during write.

## Operation
- Request fields (store, funct3, addr, wdata) registered on handshake; outputs derive from registered copies only.
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- IDLE: `req_ready`=1. On handshake: error -> RESP; load -> RD_ADDR; store -> WR.
- Error: H/HU with `addr[0]`≠0; W with `addr[1:0]`≠0; funct3 011/110/111 or store with 1xx. No memory strobe asserted.
- RD_ADDR: `mem_read_en`=1, `mem_write_en`=0. -> RD_DATA.
- RD_DATA: `mem_read_en`=1; bus carries fetched word; LSU selects lane by `addr[1:0]`, sign-extends (LB/LH) or zero-extends (LBU/LHU), registers into `resp_rdata`. -> RESP.
- WR: `mem_write_en`=1, `mem_read_en`=0; bus driven with store data replicated into lanes (SB: byte ×4, SH: half ×2, SW: word); `write_byte_en` = 0001/0011/1111 shifted left by `addr[1:0]`. -> RESP.
- RESP: `resp_valid`=1 one cycle, `req_ready`=0. -> IDLE.
- `mem_read_en` and `mem_write_en` never both 1. `mem_data` is 'z in every state except WR.
- `mem_addr` holds registered word address in all non-IDLE states; 0 in IDLE.
- `write_byte_en` 0 outside WR.

## Timing
- Handshake at edge E0. Load: RD_ADDR cycle 1, RD_DATA cycle 2, `resp_valid` cycle 3. Store: WR cycle 1, `resp_valid` cycle 2 (memory written at end of cycle 1). Error: `resp_valid` cycle 1.
- Throughput: one request per 4 (load) / 3 (store) / 2 (error) cycles; next handshake earliest in cycle after RESP.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_read_en`=0, `mem_write_en`=0, `write_byte_en`=0, `mem_addr`=0, bus 'z.
- Reset mid-operation: next cycle IDLE; in-flight request dropped, no response; a store in WR at the reset edge does not commit beyond that edge.
- `req_valid` while not ready: ignored, no side effects.

## Structure
- `lsu_pkg`: funct3 constants, state enum `lsu_state_t`, `B_WIDTH/8` lane-count constant.
- Sub-module `lsu_align`: combinational byte-enable generation, store lane replication, load lane select/extend, misalignment check; instantiated once in `mem_lsu`.

## Test plan
- Reset with bus pulled to a known value -> all outputs at reset values, `mem_data` undriven.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> `mem_addr`=4, `write_byte_en`=1111; `resp_rdata`=0xDEADBEEF on cycle 3.
- SB 0x13 data 0x000000A5 over 0x11223344, then LB 0x13 / LBU 0x13 -> lanes=1000, bus 0xA5A5A5A5; word 0xA5223344; LB=0xFFFFFFA5, LBU=0x000000A5.
- SH 0x22 data 0x8001 then LH 0x22 / LHU 0x22 -> enables 1100; LH=0xFFFF8001, LHU=0x00008001.
- LW 0x06, LH 0x03, funct3 011 -> `resp_err`=1 cycle after handshake, no read/write strobe, `resp_rdata`=0.
- Assert `rst` during RD_DATA and during WR -> IDLE next cycle, no `resp_valid`, strobes drop, bus 'z.
